multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/adder_pkg.sv | 19 +
 rtl/ripple_carry_adder.sv | 28 ++
 rtl/multiword_add_sequencer.sv | 152 +++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word add sequencer: default geometry and
// the sequencer state encoding.
package adder_pkg;

    // Default chunk width in bits, which is also the width of the shared adder.
    localparam int DEFAULT_N = 4;

    // Default number of chunks per operand.
    localparam int DEFAULT_BEATS = 4;

    // Sequencer states: waiting for operands, adding one chunk per cycle,
    // and holding the finished result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder. This is the only arithmetic element in the
// sequencer, and the sequencer uses it once per beat.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carryChain;

    // Chain of full adders from bit 0 upward. Each stage's carry-out feeds the next stage.
    always_comb begin
        carryChain    = '0;
        sum_o         = '0;
        carryChain[0] = cin_i;
        for (int i = 0; i < N; i++) begin
            sum_o[i]        = a_i[i] ^ b_i[i] ^ carryChain[i];
            carryChain[i+1] = (a_i[i] & b_i[i]) | (carryChain[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carryChain[N];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-word add sequencer.
// Adds two W = N*BEATS bit operands, one N-bit chunk per clock, using a
// single ripple_carry_adder. Handshakes are valid/ready on both sides.
// Optional feature: define ADD_SEQ_OVF_EN to add the out_ovf signed-overflow
// output.
module multiword_add_sequencer
    import adder_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int BEATS = DEFAULT_BEATS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*BEATS-1:0]   in_a,
    input  logic [N*BEATS-1:0]   in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*BEATS-1:0]   out_sum,
    output logic                 out_cout
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic                 out_ovf
`endif
);

    localparam int W  = N * BEATS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    seqState_e       state_q;
    seqState_e       state_d;
    logic [W-1:0]    opA_q;
    logic [W-1:0]    opA_d;
    logic [W-1:0]    opB_q;
    logic [W-1:0]    opB_d;
    logic [W-1:0]    sum_q;
    logic [W-1:0]    sum_d;
    logic            carry_q;
    logic            carry_d;
    logic            cout_q;
    logic            cout_d;
    logic [CW-1:0]   beat_q;
    logic [CW-1:0]   beat_d;

    logic [N-1:0]    chunkA;
    logic [N-1:0]    chunkB;
    logic [N-1:0]    chunkSum;
    logic            chunkCout;

    // The current beat selects one chunk of each registered operand for the shared adder.
    assign chunkA = opA_q[int'(beat_q)*N +: N];
    assign chunkB = opB_q[int'(beat_q)*N +: N];

    ripple_carry_adder #(
        .N (N)
    ) u_adder (
        .a_i    (chunkA),
        .b_i    (chunkB),
        .cin_i  (carry_q),
        .sum_o  (chunkSum),
        .cout_o (chunkCout)
    );

    // Next-state and handshake logic. Operands are captured only on accept.
    // RUN writes one result chunk per cycle. DONE holds the result until the consumer takes it.
    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        beat_d    = beat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opA_d   = in_a;
                    opB_d   = in_b;
                    carry_d = in_cin;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(beat_q)*N +: N] = chunkSum;
                carry_d                    = chunkCout;
                if (beat_q == LAST_BEAT) begin
                    cout_d  = chunkCout;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset drops any in-flight operation and returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operands, partial result, running carry and beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            beat_q  <= beat_d;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

`ifdef ADD_SEQ_OVF_EN
    // Signed overflow: both operands have the same sign and the sum has the other sign.
    // The output is forced low outside DONE.
    assign out_ovf = (state_q == DONE)
                   && (opA_q[W-1] == opB_q[W-1])
                   && (sum_q[W-1] != opA_q[W-1]);
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (N=4, BEATS=4).
// It runs directed vectors from a table, randomized operations, a reset
// during RUN, and back-to-back throughput. Expected results come from
// plain integer arithmetic.
module tb_multiword_add_sequencer;

    localparam int N     = 4;
    localparam int BEATS = 4;
    localparam int W     = N * BEATS;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a      = '0;
    logic [W-1:0]   in_b      = '0;
    logic           in_cin    = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_sum;
    logic           out_cout;
`ifdef ADD_SEQ_OVF_EN
    logic           out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        int           hold;
        logic [W-1:0] expSum;
        logic         expCout;
        logic         expOvf;
    } vec_t;

    vec_t vecs[9];

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    multiword_add_sequencer #(
        .N     (N),
        .BEATS (BEATS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef ADD_SEQ_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    // Reference result packed as {ovf, cout, sum}. It is computed with whole-number arithmetic.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] full;
        int         sa;
        int         sb;
        int         s;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        sa   = $signed(a);
        sb   = $signed(b);
        s    = sa + sb + int'(c);
        ovf  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return {ovf, full};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Runs one full operation. Checks in_ready at offer, latency, the result,
    // stability while the consumer stalls, and the return to IDLE.
    task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int hold, input logic [W-1:0] expSum,
                                 input logic expCout, input logic expOvf);
        int lat;
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_cin    = c;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        checkOutput({name, " in_ready at offer"}, 32'(in_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) begin
            timeoutFail({name, " out_valid"});
            return;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(BEATS));
        checkOutput({name, " sum"}, 32'(out_sum), 32'(expSum));
        checkOutput({name, " cout"}, 32'(out_cout), 32'(expCout));
`ifdef ADD_SEQ_OVF_EN
        checkOutput({name, " ovf"}, 32'(out_ovf), 32'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] note: unknown overflow expectation for %s", name);
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput({name, " hold valid"}, 32'(out_valid), 32'(1));
            checkOutput({name, " hold in_ready"}, 32'(in_ready), 32'(0));
            checkOutput({name, " hold sum"}, 32'(out_sum), 32'(expSum));
            checkOutput({name, " hold cout"}, 32'(out_cout), 32'(expCout));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " valid after take"}, 32'(out_valid), 32'(0));
        checkOutput({name, " in_ready after take"}, 32'(in_ready), 32'(1));
    endtask

    // Watchdog so the bench always ends, even if the DUT wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic [W+1:0] exp;
        logic [W+1:0] expQ[$];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           hold;
        int           cyc;
        int           lastAccept;
        int           accepted;
        int           completed;
        logic         refresh;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 5, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'hFFFF, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 2, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h000F, 16'h0001, 1'b0, 0, 16'h0010, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0, 1'b0};

        // Outputs must be cleared while reset is held.
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset out_sum", 32'(out_sum), 32'(0));
        checkOutput("reset out_cout", 32'(out_cout), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("post-reset in_ready", 32'(in_ready), 32'(1));
        checkOutput("post-reset out_valid", 32'(out_valid), 32'(0));

        // Directed vectors from the table.
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
                          vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);
        end

        // Randomized operations checked against the reference model.
        for (int i = 0; i < 12; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rc   = 1'($urandom);
            hold = $urandom_range(0, 3);
            exp  = refModel(ra, rb, rc);
            applyStimulus($sformatf("rand%0d", i), ra, rb, rc, hold, exp[W-1:0], exp[W], exp[W+1]);
        end

        // Reset pulse during beat 2 must discard the operation.
        @(negedge clk);
        in_a     = 16'h5A5A;
        in_b     = 16'h1111;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid-run reset out_valid", 32'(out_valid), 32'(0));
        checkOutput("mid-run reset out_sum", 32'(out_sum), 32'(0));
        checkOutput("mid-run reset out_cout", 32'(out_cout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("after reset in_ready", 32'(in_ready), 32'(1));
        for (int k = 0; k < BEATS + 2; k++) begin
            checkOutput("after reset no stray valid", 32'(out_valid), 32'(0));
            @(negedge clk);
        end
        applyStimulus("post-reset op", 16'h0F0F, 16'h00F1, 1'b0, 0, 16'h1000, 1'b0, 1'b0);

        // Back-to-back throughput: in_valid and out_ready held high.
        @(negedge clk);
        in_a       = W'($urandom);
        in_b       = W'($urandom);
        in_cin     = 1'($urandom);
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        cyc        = 0;
        lastAccept = -1;
        accepted   = 0;
        completed  = 0;
        refresh    = 1'b0;
        while ((accepted < 20 || expQ.size() > 0) && cyc < 400) begin
            if (refresh) begin
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_cin   = 1'($urandom);
                in_valid = (accepted < 20);
                refresh  = 1'b0;
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL throughput: unexpected out_valid, got 1, expected 0");
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("throughput sum", 32'(out_sum), 32'(exp[W-1:0]));
                    checkOutput("throughput cout", 32'(out_cout), 32'(exp[W]));
`ifdef ADD_SEQ_OVF_EN
                    checkOutput("throughput ovf", 32'(out_ovf), 32'(exp[W+1]));
`endif
                    completed++;
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(in_a, in_b, in_cin));
                if (lastAccept >= 0) begin
                    checkOutput("throughput accept spacing", 32'(cyc - lastAccept), 32'(BEATS + 2));
                end
                lastAccept = cyc;
                accepted++;
                refresh = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 400) begin
            timeoutFail("throughput drain");
        end
        checkOutput("throughput completed", 32'(completed), 32'(20));
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
